// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds reset, runs until breakpoint or cycle limit, then halts.
// Watched registers are snapshotted at halt; per-channel change flags accumulate while running.
module cpu_run_ctrl #(
    parameter int NUM_WATCH  = 5,
    parameter int DATA_W     = 32,
    parameter int CYC_W      = 32,
    parameter int RESET_HOLD = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          restart,
    input  logic [DATA_W-1:0]             pc,
    input  logic [NUM_WATCH*DATA_W-1:0]   watch_data,
    input  logic                          bp_en,
    input  logic [DATA_W-1:0]             bp_pc,
    input  logic [CYC_W-1:0]              cyc_limit,
    output logic                          cpu_reset,
    output logic                          cpu_run,
    output logic                          halted,
    output logic [1:0]                    halt_cause,
    output logic [CYC_W-1:0]              cycle_count,
    output logic [NUM_WATCH*DATA_W-1:0]   snap_data,
    output logic [NUM_WATCH-1:0]          changed
);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int HC_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(RESET_HOLD - 1);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    logic [1:0]                  state;
    logic [HC_W-1:0]             hold_cnt;
    logic [NUM_WATCH*DATA_W-1:0] prev_watch;
    logic                        bp_hit;
    logic                        lim_hit;
    logic [NUM_WATCH-1:0]        diff;

    always_comb begin
        bp_hit  = bp_en && (pc == bp_pc);
        lim_hit = (cyc_limit != '0) && (cycle_count == (cyc_limit - CYC_W'(1)));
        diff    = '0;
        for (int i = 0; i < NUM_WATCH; i++) begin
            diff[i] = (watch_data[i*DATA_W +: DATA_W] != prev_watch[i*DATA_W +: DATA_W]);
        end
    end

    // prev_watch is sampled in HOLD too, so the first RUN cycle compares against the last HOLD value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
            halt_cause  <= '0;
            changed     <= '0;
            snap_data   <= '0;
            prev_watch  <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    prev_watch <= watch_data;
                    if (hold_cnt == HC_LAST) begin
                        state    <= S_RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                S_RUN: begin
                    prev_watch <= watch_data;
                    changed    <= changed | diff;
                    if (cycle_count != CYC_MAX) begin
                        cycle_count <= cycle_count + CYC_W'(1);
                    end
                    if (bp_hit || lim_hit) begin
                        state      <= S_HALT;
                        halt_cause <= {lim_hit, bp_hit};
                        snap_data  <= watch_data;
                    end
                end
                S_HALT: begin
                    if (restart) begin
                        state       <= S_HOLD;
                        hold_cnt    <= '0;
                        cycle_count <= '0;
                        halt_cause  <= '0;
                        changed     <= '0;
                    end
                end
                default: begin
                    state    <= S_HOLD;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_reset = (state == S_HOLD);
    assign cpu_run   = (state == S_RUN);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_cpu_run_ctrl;
    localparam int NW = 5;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int RH = 2;
    localparam logic [DW-1:0] PC_BASE = 32'h0040_0000;
    localparam longint unsigned CNT_MAX = (64'd1 << CW) - 1;

    logic              clk = 0;
    logic              reset, restart, bp_en;
    logic [DW-1:0]     pc, bp_pc;
    logic [NW*DW-1:0]  watch_data;
    logic [CW-1:0]     cyc_limit;
    logic              cpu_reset, cpu_run, halted;
    logic [1:0]        halt_cause;
    logic [CW-1:0]     cycle_count;
    logic [NW*DW-1:0]  snap_data;
    logic [NW-1:0]     changed;

    int vectors = 0;
    int miscompares = 0;

    cpu_run_ctrl #(.NUM_WATCH(NW), .DATA_W(DW), .CYC_W(CW), .RESET_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .restart(restart), .pc(pc), .watch_data(watch_data),
        .bp_en(bp_en), .bp_pc(bp_pc), .cyc_limit(cyc_limit), .cpu_reset(cpu_reset),
        .cpu_run(cpu_run), .halted(halted), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .snap_data(snap_data), .changed(changed)
    );

    always #5 clk = ~clk;

    // Behavioural model: reset cycles still owed, run/halt flags, counters and captured data.
    int               m_left;
    bit               m_run, m_halt;
    longint unsigned  m_cnt;
    logic [1:0]       m_cause;
    logic [NW*DW-1:0] m_snap, m_prev;
    logic [NW-1:0]    m_chg;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit bp, lim;
        if (reset) begin
            m_left = RH; m_run = 0; m_halt = 0; m_cnt = 0;
            m_cause = 0; m_chg = 0; m_snap = 0; m_prev = watch_data;
        end else if (m_halt) begin
            if (restart) begin
                m_left = RH; m_halt = 0; m_cnt = 0; m_cause = 0; m_chg = 0;
            end
        end else if (m_left > 0) begin
            m_prev = watch_data;
            m_left--;
            if (m_left == 0) m_run = 1;
        end else begin
            for (int i = 0; i < NW; i++)
                if (watch_data[i*DW +: DW] != m_prev[i*DW +: DW]) m_chg[i] = 1'b1;
            m_prev = watch_data;
            bp  = bp_en && (pc == bp_pc);
            lim = (cyc_limit != 0) && (m_cnt == longint'(cyc_limit) - 1);
            if (m_cnt < CNT_MAX) m_cnt++;
            if (bp || lim) begin
                m_run = 0; m_halt = 1; m_cause = {lim, bp}; m_snap = watch_data;
            end
        end
    endtask

    task automatic compare_all();
        chk("cpu_reset",   cpu_reset,   m_left > 0);
        chk("cpu_run",     cpu_run,     m_run);
        chk("halted",      halted,      m_halt);
        chk("halt_cause",  halt_cause,  m_cause);
        chk("cycle_count", cycle_count, m_cnt);
        chk("snap_data",   snap_data,   m_snap);
        chk("changed",     changed,     m_chg);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_restart();
        int n;
        restart = 1; tick(); restart = 0;
        chk("restart_cnt_clr", cycle_count, 0);
        chk("restart_chg_clr", changed, 0);
        n = 0;
        while (cpu_reset === 1'b1 && n < 10) begin n++; tick(); end
        chk("restart_hold_len", n, RH);
    endtask

    // Runs with pc stepping by 4 per RUN cycle; returns watch value presented in the final cycle.
    task automatic run_to_halt(input string name, output logic [NW*DW-1:0] last_wd);
        int n = 0;
        last_wd = watch_data;
        while (halted !== 1'b1 && n < 200) begin
            pc = PC_BASE + DW'(4 * m_cnt);
            for (int i = 0; i < NW; i++) watch_data[i*DW +: DW] = $urandom;
            last_wd = watch_data;
            tick();
            n++;
        end
        chk({name, "_halt_timeout"}, halted, 1'b1);
    endtask

    initial begin
        logic [NW*DW-1:0] last_wd;
        int n;
        reset = 1; restart = 0; bp_en = 0; bp_pc = '0; pc = PC_BASE;
        watch_data = '0; cyc_limit = 10;
        repeat (3) tick();
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_snap", snap_data, 0);

        // Cycle limit of 10, no breakpoint.
        reset = 0;
        n = 0;
        while (cpu_reset === 1'b1 && n < 10) begin n++; tick(); end
        chk("lim_hold_len", n, 2);
        n = 0;
        while (cpu_run === 1'b1 && n < 50) begin n++; tick(); end
        chk("lim_run_len", n, 10);
        chk("lim_halted", halted, 1'b1);
        chk("lim_cause", halt_cause, 2'b10);
        chk("lim_count", cycle_count, 10);
        repeat (3) tick();

        // Breakpoint at the fifth RUN cycle.
        cyc_limit = 0; bp_en = 1; bp_pc = 32'h0040_0010;
        do_restart();
        run_to_halt("bp", last_wd);
        chk("bp_cause", halt_cause, 2'b01);
        chk("bp_count", cycle_count, 5);
        chk("bp_snap", snap_data, last_wd);

        // Breakpoint and limit land on the same cycle.
        cyc_limit = 5;
        do_restart();
        run_to_halt("both", last_wd);
        chk("both_cause", halt_cause, 2'b11);
        chk("both_count", cycle_count, 5);

        // Only channel 2 changes; restart mid-run must be ignored.
        bp_en = 0; cyc_limit = 10;
        for (int i = 0; i < NW; i++) watch_data[i*DW +: DW] = DW'(32'h1000 + i);
        do_restart();
        n = 0;
        while (halted !== 1'b1 && n < 50) begin
            restart = (m_cnt == 2);
            if (m_cnt == 4) watch_data[2*DW +: DW] = 32'hDEAD_BEEF;
            tick();
            n++;
        end
        restart = 0;
        chk("chg_cpu_run_ignore", cycle_count, 10);
        chk("chg_flags", changed, 5'b00100);
        repeat (4) tick();
        chk("chg_flags_held", changed, 5'b00100);

        // Reset asserted mid-run with cycle_count at 7.
        cyc_limit = 0;
        do_restart();
        n = 0;
        while (cycle_count !== 7 && n < 50) begin n++; tick(); end
        reset = 1; tick(); reset = 0;
        chk("midrst_cpu_reset", cpu_reset, 1'b1);
        chk("midrst_count", cycle_count, 0);
        chk("midrst_run", cpu_run, 1'b0);
        chk("midrst_snap", snap_data, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            restart = ($urandom_range(0, 5) == 0);
            bp_en   = $urandom_range(0, 1);
            pc      = PC_BASE + DW'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) bp_pc = PC_BASE + DW'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) cyc_limit = CW'($urandom_range(0, 25));
            for (int i = 0; i < NW; i++)
                if ($urandom_range(0, 9) == 0) watch_data[i*DW +: DW] = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_WATCH, default 5, number of watched CPU register channels.
REQ-002 SHALL have parameter DATA_W, default 32, width of PC and each watched value.
REQ-003 SHALL have parameter CYC_W, default 32, width of cycle counter and limit.
REQ-004 SHALL have parameter RESET_HOLD, default 2 (legal >=1), cycles cpu_reset is held per start.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port restart  input  1  single-cycle request to rerun the CPU from HALT.
REQ-008 SHALL have port pc  input  DATA_W  CPU program counter of the current cycle.
REQ-009 SHALL have port watch_data  input  NUM_WATCH*DATA_W  watched registers; channel i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port bp_en  input  1  enables the PC breakpoint.
REQ-011 SHALL have port bp_pc  input  DATA_W  breakpoint address.
REQ-012 SHALL have port cyc_limit  input  CYC_W  run-cycle limit; 0 = unlimited.
REQ-013 SHALL have port cpu_reset  output  1  reset to CPU, active-high.
REQ-014 SHALL have port cpu_run  output  1  high only in RUN.
REQ-015 SHALL have port halted  output  1  high only in HALT.
REQ-016 SHALL have port halt_cause  output  2  bit0 = breakpoint hit, bit1 = cycle limit reached.
REQ-017 SHALL have port cycle_count  output  CYC_W  RUN cycles since last start.
REQ-018 SHALL have port snap_data  output  NUM_WATCH*DATA_W  watch_data captured at halt.
REQ-019 SHALL have port changed  output  NUM_WATCH  sticky per-channel change flags.

Function
REQ-020 SHALL implement states HOLD, RUN, HALT; cpu_reset=1 only in HOLD.
REQ-021 HOLD SHALL count hold_cnt from 0; at hold_cnt==RESET_HOLD-1 next state RUN, so cpu_reset is high exactly RESET_HOLD cycles.
REQ-022 On HOLD entry cycle_count, halt_cause, changed SHALL clear to 0; snap_data retained.
REQ-023 In RUN cycle_count SHALL increment by 1 per cycle, saturating at all-ones (no wrap).
REQ-024 RUN halt test each cycle: bp_hit = bp_en && pc==bp_pc; lim_hit = cyc_limit!=0 && cycle_count==cyc_limit-1.
REQ-025 If bp_hit or lim_hit, next state SHALL be HALT, halt_cause<={lim_hit,bp_hit} (both set if simultaneous), snap_data<=watch_data of that cycle, and cycle_count still increments that cycle.
REQ-026 cpu_run and halted SHALL be registered state decodes, visible the cycle after the halting condition.
REQ-027 In RUN changed[i] SHALL set when watch_data channel i differs from its value in the previous cycle; first RUN cycle compares against value sampled in last HOLD cycle; set bits stay set until HOLD entry.
REQ-028 In HALT outputs SHALL be frozen; restart SHALL move to HOLD next cycle.
REQ-029 restart SHALL be ignored in HOLD and RUN.
REQ-030 Changes to bp_en, bp_pc, cyc_limit SHALL take effect the cycle they are presented.
REQ-031 cyc_limit==1 SHALL halt after exactly one RUN cycle (cycle_count=1).

Reset
REQ-032 reset SHALL take priority over all inputs, in any state, including mid-RUN.
REQ-033 While reset high: state=HOLD, hold_cnt=0, cpu_reset=1, cpu_run=0, halted=0, halt_cause=0, cycle_count=0, changed=0, snap_data=0.
REQ-034 After reset falls, cpu_reset SHALL stay high exactly RESET_HOLD further cycles.

Verification
REQ-035 Defaults, cyc_limit=10, bp_en=0, release reset -> cpu_reset high 2 cycles, RUN 10 cycles, halted=1, halt_cause=2'b10, cycle_count=10.
REQ-036 bp_en=1, bp_pc=0x0040_0010, pc stepping by 4 from 0x0040_0000 each RUN cycle -> halt after 5th RUN cycle, halt_cause=2'b01, snap_data equals watch_data of that cycle.
REQ-037 bp_pc reached on same cycle lim_hit true (cyc_limit=5, same PC sequence) -> halt_cause=2'b11, cycle_count=5.
REQ-038 In HALT pulse restart -> 2 cycles cpu_reset=1, cycle_count and changed zeroed, RUN resumes; restart pulsed during RUN -> no effect.
REQ-039 Change only channel 2 (v0) mid-RUN, others constant -> changed=5'b00100, held through HALT.
REQ-040 Assert reset mid-RUN at cycle_count=7 -> next cycle all outputs at reset values, cpu_reset=1.
